// File: rtl/oldland_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : oldland_mem_arbiter
// Brief   : N-master to single-slave memory bus arbiter, round-robin or fixed
//           priority, with an optional bus timeout error.
// Revision: 1.0 - initial release
// ============================================================================
module oldland_mem_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 30,
    parameter int DATA_WIDTH     = 32,
    parameter int ROUND_ROBIN    = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_MASTERS-1:0]                 m_access,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_bytesel,
    input  logic [NUM_MASTERS-1:0]                 m_wr_en,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_wr_val,
    output logic [DATA_WIDTH-1:0]                  m_data,
    output logic [NUM_MASTERS-1:0]                 m_ack,
    output logic [NUM_MASTERS-1:0]                 m_error,
    output logic                                   s_access,
    output logic [ADDR_WIDTH-1:0]                  s_addr,
    output logic [DATA_WIDTH/8-1:0]                s_bytesel,
    output logic                                   s_wr_en,
    output logic [DATA_WIDTH-1:0]                  s_wr_val,
    input  logic [DATA_WIDTH-1:0]                  s_data,
    input  logic                                   s_ack,
    input  logic                                   s_error,
    output logic [NUM_MASTERS-1:0]                 grant
);

    localparam int c_BSEL_W = DATA_WIDTH / 8;
    localparam int c_IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit c_TO_EN  = (TIMEOUT_CYCLES > 0);
    localparam logic [c_IDX_W:0]   c_N        = (c_IDX_W+1)'(NUM_MASTERS);
    localparam logic [c_IDX_W-1:0] c_PTR_RST  = c_IDX_W'(NUM_MASTERS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state, w_next_state;
    logic [NUM_MASTERS-1:0] r_grant, w_next_grant;
    logic [c_IDX_W-1:0]     r_rr_ptr, w_next_ptr;
    logic [c_CNT_W-1:0]     r_count, w_next_count;

    logic [NUM_MASTERS-1:0] w_winner;
    logic [c_IDX_W-1:0]     w_winner_idx;
    logic [c_IDX_W-1:0]     w_cand;
    logic [c_IDX_W:0]       w_sum;
    logic                   w_found;
    logic                   w_busy;
    logic                   w_timeout;
    logic                   w_done;

    assign w_busy    = (r_state == ST_BUSY);
    assign w_timeout = c_TO_EN && w_busy && (r_count == c_CNT_LAST) && !s_ack && !s_error;
    assign w_done    = s_ack || s_error || w_timeout;

    // Candidate order: pointer+1 upward with wrap for round-robin, index order otherwise.
    always_comb begin
        w_found      = 1'b0;
        w_winner     = '0;
        w_winner_idx = '0;
        w_cand       = '0;
        w_sum        = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            if (ROUND_ROBIN != 0) begin
                w_sum = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
                if (w_sum >= c_N) begin
                    w_sum = w_sum - c_N;
                end
                w_cand = w_sum[c_IDX_W-1:0];
            end else begin
                w_cand = c_IDX_W'(k - 1);
            end
            if (!w_found && m_access[w_cand]) begin
                w_found          = 1'b1;
                w_winner[w_cand] = 1'b1;
                w_winner_idx     = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= c_PTR_RST;
            r_count  <= '0;
        end else begin
            r_state  <= w_next_state;
            r_grant  <= w_next_grant;
            r_rr_ptr <= w_next_ptr;
            r_count  <= w_next_count;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_grant = r_grant;
        w_next_ptr   = r_rr_ptr;
        w_next_count = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_BUSY;
                    w_next_grant = w_winner;
                    w_next_ptr   = w_winner_idx;
                    w_next_count = '0;
                end
            end
            ST_BUSY: begin
                if (w_done) begin
                    w_next_state = ST_IDLE;
                    w_next_grant = '0;
                end else if (c_TO_EN) begin
                    w_next_count = r_count + c_CNT_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_grant = '0;
            end
        endcase
    end

    // Grant is one-hot (or zero), so OR-ing masked slices forms the mux.
    always_comb begin
        s_addr    = '0;
        s_bytesel = '0;
        s_wr_en   = 1'b0;
        s_wr_val  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (r_grant[i]) begin
                s_addr    = s_addr    | m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_bytesel = s_bytesel | m_bytesel[i*c_BSEL_W +: c_BSEL_W];
                s_wr_en   = s_wr_en   | m_wr_en[i];
                s_wr_val  = s_wr_val  | m_wr_val[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign s_access = w_busy;
    assign grant    = r_grant;
    assign m_data   = s_data;
    assign m_ack    = w_busy ? (r_grant & {NUM_MASTERS{s_ack}}) : '0;
    assign m_error  = w_busy ? (r_grant & {NUM_MASTERS{s_error || w_timeout}}) : '0;

endmodule
`default_nettype wire

// File: tb/tb_oldland_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_oldland_mem_arbiter
// Brief   : Directed self-checking bench for oldland_mem_arbiter in three
//           configurations (2-master RR with timeout, 2-master fixed, 4-master RR).
// Revision: 1.0 - initial release
// ============================================================================
`define STEP @(posedge clk); #1

module tb_oldland_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   acks;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Instance A: 2 masters, round-robin, timeout 8
    logic [1:0]  a_m_access, a_m_wr_en, a_m_ack, a_m_error, a_grant;
    logic [59:0] a_m_addr;
    logic [7:0]  a_m_bytesel;
    logic [63:0] a_m_wr_val;
    logic [31:0] a_m_data, a_s_wr_val, a_s_data;
    logic        a_s_access, a_s_wr_en, a_s_ack, a_s_ack_man, a_auto;
    logic [29:0] a_s_addr;
    logic [3:0]  a_s_bytesel;
    assign a_s_ack = a_auto ? a_s_access : a_s_ack_man;

    oldland_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32),
                          .ROUND_ROBIN(1), .TIMEOUT_CYCLES(8)) u_a (
        .clk(clk), .rst_n(rst_n), .m_access(a_m_access), .m_addr(a_m_addr),
        .m_bytesel(a_m_bytesel), .m_wr_en(a_m_wr_en), .m_wr_val(a_m_wr_val),
        .m_data(a_m_data), .m_ack(a_m_ack), .m_error(a_m_error),
        .s_access(a_s_access), .s_addr(a_s_addr), .s_bytesel(a_s_bytesel),
        .s_wr_en(a_s_wr_en), .s_wr_val(a_s_wr_val), .s_data(a_s_data),
        .s_ack(a_s_ack), .s_error(1'b0), .grant(a_grant));

    // Instance B: 2 masters, fixed priority, no timeout, slave acks immediately
    logic [1:0]  b_m_access, b_m_ack, b_m_error, b_grant;
    logic [31:0] b_m_data, b_s_wr_val;
    logic        b_s_access, b_s_wr_en;
    logic [29:0] b_s_addr;
    logic [3:0]  b_s_bytesel;

    oldland_mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(30), .DATA_WIDTH(32),
                          .ROUND_ROBIN(0), .TIMEOUT_CYCLES(0)) u_b (
        .clk(clk), .rst_n(rst_n), .m_access(b_m_access), .m_addr(60'h0),
        .m_bytesel(8'h0), .m_wr_en(2'b00), .m_wr_val(64'h0),
        .m_data(b_m_data), .m_ack(b_m_ack), .m_error(b_m_error),
        .s_access(b_s_access), .s_addr(b_s_addr), .s_bytesel(b_s_bytesel),
        .s_wr_en(b_s_wr_en), .s_wr_val(b_s_wr_val), .s_data(32'h0),
        .s_ack(b_s_access), .s_error(1'b0), .grant(b_grant));

    // Instance C: 4 masters, round-robin, no timeout, slave acks immediately
    logic [3:0]   c_m_access, c_m_wr_en, c_m_ack, c_m_error, c_grant;
    logic [119:0] c_m_addr;
    logic [15:0]  c_m_bytesel;
    logic [127:0] c_m_wr_val;
    logic [31:0]  c_m_data, c_s_wr_val;
    logic         c_s_access, c_s_wr_en;
    logic [29:0]  c_s_addr;
    logic [3:0]   c_s_bytesel;

    oldland_mem_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(30), .DATA_WIDTH(32),
                          .ROUND_ROBIN(1), .TIMEOUT_CYCLES(0)) u_c (
        .clk(clk), .rst_n(rst_n), .m_access(c_m_access), .m_addr(c_m_addr),
        .m_bytesel(c_m_bytesel), .m_wr_en(c_m_wr_en), .m_wr_val(c_m_wr_val),
        .m_data(c_m_data), .m_ack(c_m_ack), .m_error(c_m_error),
        .s_access(c_s_access), .s_addr(c_s_addr), .s_bytesel(c_s_bytesel),
        .s_wr_en(c_s_wr_en), .s_wr_val(c_s_wr_val), .s_data(32'h0),
        .s_ack(c_s_access), .s_error(1'b0), .grant(c_grant));

    logic [1:0] exp_rr  [8];
    logic [1:0] exp_fix [8];

    initial begin
        exp_rr  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        exp_fix = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        rst_n = 1'b0;
        a_m_access = '0; a_m_wr_en = '0; a_m_addr = '0; a_m_bytesel = '0; a_m_wr_val = '0;
        a_s_data = '0; a_s_ack_man = 1'b0; a_auto = 1'b0;
        b_m_access = '0;
        c_m_access = '0; c_m_wr_en = '0; c_m_addr = '0; c_m_bytesel = '0; c_m_wr_val = '0;

        // Reset state
        `STEP; `STEP;
        #1;
        check("rst_a_grant", a_grant, 2'b00);
        check("rst_a_s_access", a_s_access, 1'b0);
        check("rst_b_grant", b_grant, 2'b00);
        check("rst_c_grant", c_grant, 4'b0000);
        check("rst_c_s_access", c_s_access, 1'b0);

        // Single read from master 0, slave acks in the third busy cycle
        `STEP; rst_n = 1'b1; a_m_access = 2'b01; a_m_addr[29:0] = 30'h100; #1;
        check("t1_no_access_yet", a_s_access, 1'b0);
        `STEP; #1;
        check("t1_s_access", a_s_access, 1'b1);
        check("t1_grant", a_grant, 2'b01);
        check("t1_s_addr", a_s_addr, 30'h100);
        check("t1_no_early_ack", a_m_ack, 2'b00);
        `STEP; #1;
        check("t1_no_ack_c2", a_m_ack, 2'b00);
        `STEP; a_s_ack_man = 1'b1; a_s_data = 32'hdeadbeef; #1;
        check("t1_ack", a_m_ack, 2'b01);
        check("t1_data", a_m_data, 32'hdeadbeef);
        check("t1_no_err", a_m_error, 2'b00);
        `STEP; a_s_ack_man = 1'b0; a_m_access = 2'b00; #1;
        check("t1_access_drop", a_s_access, 1'b0);
        check("t1_grant_clear", a_grant, 2'b00);
        check("t1_ack_pulse", a_m_ack, 2'b00);

        // Round-robin alternation after a fresh reset
        `STEP; rst_n = 1'b0; #1;
        `STEP; rst_n = 1'b1; a_auto = 1'b1; a_m_access = 2'b11; #1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            `STEP; #1;
            check("rr_grant", a_grant, exp_rr[i]);
            check("rr_ack", a_m_ack, exp_rr[i]);
            if (a_m_ack != 2'b00) acks++;
            if (i == 7) a_m_access = 2'b00;
        end
        check("rr_ack_count", acks, 4);

        // Timeout: slave never answers master 0
        `STEP; a_auto = 1'b0; a_m_access = 2'b01; #1;
        for (int j = 1; j <= 8; j++) begin
            `STEP; #1;
            check("to_s_access", a_s_access, 1'b1);
            check("to_error", a_m_error, (j == 8) ? 2'b01 : 2'b00);
            if (j == 8) a_m_access = 2'b00;
        end
        `STEP; a_s_ack_man = 1'b1; #1;
        check("to_access_drop", a_s_access, 1'b0);
        check("to_grant_clear", a_grant, 2'b00);
        check("late_ack_ignored", a_m_ack, 2'b00);
        check("to_err_pulse", a_m_error, 2'b00);

        // Ack on the expiry cycle wins over the timeout
        `STEP; a_s_ack_man = 1'b0; a_m_access = 2'b01; #1;
        for (int j = 1; j <= 8; j++) begin
            `STEP; if (j == 8) a_s_ack_man = 1'b1; #1;
            if (j == 8) begin
                check("exp_ack_wins", a_m_ack, 2'b01);
                check("exp_no_error", a_m_error, 2'b00);
            end
        end
        `STEP; a_s_ack_man = 1'b0; a_m_access = 2'b00; #1;
        check("exp_idle", a_s_access, 1'b0);

        // Reset in the middle of a transaction from master 1
        `STEP; a_m_access = 2'b10; #1;
        `STEP; #1;
        check("mr_grant", a_grant, 2'b10);
        `STEP; rst_n = 1'b0; #1;
        `STEP; rst_n = 1'b1; a_m_access = 2'b11; #1;
        check("mr_access", a_s_access, 1'b0);
        check("mr_grant_clear", a_grant, 2'b00);
        check("mr_no_ack", a_m_ack, 2'b00);
        check("mr_no_error", a_m_error, 2'b00);
        `STEP; #1;
        check("mr_m0_first", a_grant, 2'b01);
        `STEP; a_m_access = 2'b00; #1;

        // Fixed priority: master 0 wins every arbitration
        `STEP; b_m_access = 2'b11; #1;
        for (int i = 0; i < 8; i++) begin
            `STEP; #1;
            check("fix_grant", b_grant, exp_fix[i]);
            check("fix_ack", b_m_ack, exp_fix[i]);
            if (i == 7) b_m_access = 2'b10;
        end
        `STEP; #1;
        check("fix_m1_after_drop", b_grant, 2'b10);
        `STEP; b_m_access = 2'b00; #1;

        // Four masters: move pointer to 1, then masters 1 and 3 compete
        c_m_addr[1*30 +: 30]    = 30'h111;
        c_m_addr[3*30 +: 30]    = 30'h333;
        c_m_wr_en               = 4'b1000;
        c_m_wr_val[3*32 +: 32]  = 32'h12345678;
        c_m_bytesel[3*4 +: 4]   = 4'b0011;
        c_m_wr_val[1*32 +: 32]  = 32'hcafef00d;
        c_m_bytesel[1*4 +: 4]   = 4'b1111;
        `STEP; c_m_access = 4'b0010; #1;
        `STEP; #1;
        check("n4_first_grant", c_grant, 4'b0010);
        check("n4_first_addr", c_s_addr, 30'h111);
        check("n4_first_ack", c_m_ack, 4'b0010);
        `STEP; c_m_access = 4'b1010; #1;
        check("n4_bubble", c_grant, 4'b0000);
        `STEP; #1;
        check("n4_grant_m3", c_grant, 4'b1000);
        check("n4_s_addr", c_s_addr, 30'h333);
        check("n4_s_wr_en", c_s_wr_en, 1'b1);
        check("n4_s_wr_val", c_s_wr_val, 32'h12345678);
        check("n4_s_bytesel", c_s_bytesel, 4'b0011);
        check("n4_ack_m3", c_m_ack, 4'b1000);
        `STEP; c_m_access = 4'b0010; #1;
        check("n4_bubble2", c_grant, 4'b0000);
        `STEP; #1;
        check("n4_grant_m1", c_grant, 4'b0010);
        check("n4_m1_rd", c_s_wr_en, 1'b0);
        `STEP; c_m_access = 4'b0000; #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
